avm_copy_master: RTL and testbench
==================================

# avm_copy_master

Avalon-MM initiator that copies a block of 32-bit words from a source word address to a destination word address over a single memory-mapped port, one word at a time. It drives the same chipselect/read/write/byteenable slave interface our on-chip RAMs expose, so game logic can move board and piece buffers without CPU involvement. It sits between a control FSM (start/len/addresses) and the Avalon fabric or a directly attached on-chip memory.

## Interface
- ADDR_W, 16: word-address width on the bus.
- DATA_W, 32: data width; fixed at 32 for byteenable width 4.
- LEN_W, 8: width of the word-count input.
- READ_LATENCY, 1: fixed read latency in cycles after an accepted read; legal 1..4.

- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address, latched on start.
- dst_addr  in  ADDR_W  first destination word address, latched on start.
- len  in  LEN_W  number of words, latched on start.
- busy  out  1  high from the cycle after accepted start until DONE exits.
- done  out  1  one-cycle pulse at completion.
- avm_address  out  ADDR_W  word address.
- avm_chipselect  out  1  asserted with every read or write.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_byteenable  out  4  always 4'hF while chipselect is high, else 0.
- avm_writedata  out  DATA_W  captured read word (or fill word).
- avm_readdata  in  DATA_W  valid READ_LATENCY cycles after accepted read.
- avm_waitrequest  in  1  slave stall; a request is accepted on the cycle it is low.

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE: start=1 latches src/dst/len; len==0 -> DONE, else -> RD_REQ. start while busy is ignored.
- RD_REQ: chipselect=read=1, address=src; hold until waitrequest=0, then -> RD_WAIT.
- RD_WAIT: count READ_LATENCY cycles from acceptance; capture avm_readdata into data register on the final count, -> WR_REQ.
- WR_REQ: chipselect=write=1, address=dst, writedata=data register; hold until waitrequest=0; on acceptance src+=1, dst+=1, remaining-=1; remaining reaches 0 -> DONE, else -> RD_REQ.
- DONE: done=1 for one cycle, -> IDLE.
- Address arithmetic is modulo 2^ADDR_W (wrap from all-ones to 0, no error).
- Outputs never assert read and write together; all bus outputs are 0 in IDLE, RD_WAIT and DONE.
- Reset (any state): state=IDLE, busy=0, done=0, all avm_* outputs 0, counters 0; an in-flight transfer is abandoned.

## Timing
- Start sampled in cycle 0; first RD_REQ cycle is cycle 1.
- With waitrequest=0 and READ_LATENCY=L: per word 1 + L + 1 cycles; done asserted in cycle 1 + N*(L+2).
- len==0: done in cycle 1, no bus activity.
- Each waitrequest=1 cycle adds one cycle; outputs held stable while stalled.
- Read data captured exactly L cycles after the accepted-read cycle; waitrequest is ignored in RD_WAIT.

## Configuration
- AVM_COPY_FILL_EN defined: adds ports fill_mode (in, 1) and fill_data (in, DATA_W), latched on start; with fill_mode=1 the FSM skips RD_REQ/RD_WAIT and writes fill_data to len consecutive destination words (1 cycle per word unstalled); src_addr ignored.
- Undefined: ports absent, copy-only behaviour as above.

## Structure
- Package avm_copy_pkg: state enum type, BYTEEN_ALL = 4'hF constant, READ_LATENCY legal-range check constant.
- Single module; no sub-module needed (latency counter is inline, width ceil(log2(4))+1).

## Test plan
- Copy len=4, src=0x0000, dst=0x0008, L=1, memory preset 0x11..0x44 -> words at 0x8..0xB equal 0x11,0x22,0x33,0x44; done in cycle 13.
- len=0 start -> done in cycle 1, chipselect never asserted, busy high for exactly one cycle.
- waitrequest high 3 cycles on the second write -> address/writedata held stable, done delayed by exactly 3 cycles, data correct.
- src=0xFFFF, len=2 -> reads from 0xFFFF then 0x0000 (wrap).
- start pulsed while busy -> ignored; reset asserted mid-RD_WAIT -> next cycle all outputs 0, state IDLE, new start runs cleanly.
- AVM_COPY_FILL_EN, fill_mode=1, fill_data=0xDEADBEEF, len=3, dst=0x20 -> 0x20..0x22 hold 0xDEADBEEF, no reads, done in cycle 4.

Source files
------------

// File: rtl/avm_copy_pkg.sv
// avm_copy_pkg: shared FSM state type and constants for avm_copy_master.
package avm_copy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // Every bus access is a full 32-bit word.
   localparam logic [3:0] BYTEEN_ALL = 4'hF;

   // Supported range of the slave's fixed read latency.
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

   // Latency counter width: ceil(log2(RD_LAT_MAX)) + 1.
   localparam int LAT_CNT_W = $clog2(RD_LAT_MAX) + 1;

endpackage

// File: rtl/avm_copy_master.sv
// avm_copy_master: Avalon-MM initiator that copies len 32-bit words from
// src_addr to dst_addr, one read followed by one write per word.
// Optional build macro AVM_COPY_FILL_EN adds fill_mode/fill_data ports that
// write a constant word to len destination words without reading.
module avm_copy_master
   import avm_copy_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 32,
   parameter int LEN_W        = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
`ifdef AVM_COPY_FILL_EN
   input  logic              fill_mode,
   input  logic [DATA_W-1:0] fill_data,
`endif
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_read,
   output logic              avm_write,
   output logic [3:0]        avm_byteenable,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_waitrequest
);

   if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_latency
      $error("avm_copy_master: READ_LATENCY must be within 1..4");
   end

   // Index of the RD_WAIT cycle in which read data is valid.
   localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(READ_LATENCY - 1);

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    src_q, src_d;
   logic [ADDR_W-1:0]    dst_q, dst_d;
   logic [LEN_W-1:0]     rem_q, rem_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic [LAT_CNT_W-1:0] lat_q, lat_d;
   logic                 fill_q, fill_d;

   logic                 fill_req;
   logic [DATA_W-1:0]    fill_word;

`ifdef AVM_COPY_FILL_EN
   assign fill_req  = fill_mode;
   assign fill_word = fill_data;
`else
   assign fill_req  = 1'b0;
   assign fill_word = '0;
`endif

   // State and datapath registers; reset abandons any transfer in flight.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (reset) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         lat_q   <= '0;
         fill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         lat_q   <= lat_d;
         fill_q  <= fill_d;
      end
   end

   // Next-state and datapath update: sequences read/wait/write per word.
   always_comb begin
      // NOTE: hold-value defaults up front so no path leaves a latch behind.
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      data_d  = data_q;
      lat_d   = lat_q;
      fill_d  = fill_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_d  = src_addr;
               dst_d  = dst_addr;
               rem_d  = len;
               lat_d  = '0;
               fill_d = fill_req;
               if (fill_req) data_d = fill_word;
               if (len == '0)    state_d = ST_DONE;
               else if (fill_req) state_d = ST_WR_REQ;
               else               state_d = ST_RD_REQ;
            end
         end
         ST_RD_REQ: begin
            if (!avm_waitrequest) begin
               lat_d   = '0;
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            // Waitrequest has no meaning here; only the latency count matters.
            if (lat_q == LAT_LAST) begin
               data_d  = avm_readdata;
               state_d = ST_WR_REQ;
            end else begin
               lat_d = lat_q + LAT_CNT_W'(1);
            end
         end
         ST_WR_REQ: begin
            if (!avm_waitrequest) begin
               src_d = src_q + ADDR_W'(1);
               dst_d = dst_q + ADDR_W'(1);
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) state_d = ST_DONE;
               else if (fill_q)        state_d = ST_WR_REQ;
               else                    state_d = ST_RD_REQ;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus and status outputs decoded from the current state only.
   always_comb begin
      busy           = (state_q != ST_IDLE);
      done           = (state_q == ST_DONE);
      avm_chipselect = 1'b0;
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      avm_byteenable = '0;
      avm_address    = '0;
      avm_writedata  = '0;
      case (state_q)
         ST_RD_REQ: begin
            avm_chipselect = 1'b1;
            avm_read       = 1'b1;
            avm_byteenable = BYTEEN_ALL;
            avm_address    = src_q;
         end
         ST_WR_REQ: begin
            avm_chipselect = 1'b1;
            avm_write      = 1'b1;
            avm_byteenable = BYTEEN_ALL;
            avm_address    = dst_q;
            avm_writedata  = data_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_avm_copy_master.sv
// tb_avm_copy_master: directed and randomized copies against a word-level
// reference model; the bench also acts as the Avalon slave memory.
`timescale 1ns/1ps
module tb_avm_copy_master;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 8;
   localparam int RL     = 1;
   localparam int LIMIT  = 4000;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] src_addr, dst_addr;
   logic [LEN_W-1:0]  len;
`ifdef AVM_COPY_FILL_EN
   logic              fill_mode;
   logic [DATA_W-1:0] fill_data;
`endif
   logic              busy, done;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_chipselect, avm_read, avm_write;
   logic [3:0]        avm_byteenable;
   logic [DATA_W-1:0] avm_writedata, avm_readdata;
   logic              avm_waitrequest;

   typedef struct { bit is_wr; logic [15:0] addr; logic [31:0] data; } op_t;
   typedef struct { int due; logic [31:0] data; } rd_t;

   logic [31:0] mem     [0:65535];
   logic [31:0] ref_mem [0:65535];
   op_t exp_ops[$];
   op_t obs_ops[$];
   rd_t pend[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;
   int done_cyc;
   int stall_total;

   always #5 clk = ~clk;

   avm_copy_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
`ifdef AVM_COPY_FILL_EN
      .fill_mode(fill_mode), .fill_data(fill_data),
`endif
      .busy(busy), .done(done),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_read(avm_read), .avm_write(avm_write),
      .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_idle(input string tag);
      check({tag, ":busy"}, busy, 0);
      check({tag, ":done"}, done, 0);
      check({tag, ":bus"}, {avm_chipselect, avm_read, avm_write, avm_byteenable,
                           avm_address, avm_writedata}, 0);
   endtask

   // Present read data exactly RL cycles after the accepted read, junk otherwise.
   task automatic drive_rdata();
      if (pend.size() > 0 && pend[0].due == cyc) begin
         avm_readdata = pend[0].data;
         void'(pend.pop_front());
      end else begin
         avm_readdata = $urandom();
      end
   endtask

   // mode 0: no stalls; 1: random waitrequest every cycle;
   // 2: stall write number st_idx (0-based) for st_len cycles.
   task automatic run_xfer(input string tag, input logic [15:0] s, input logic [15:0] d,
                           input logic [7:0] n, input bit fill, input logic [31:0] fdata,
                           input int mode, input int st_idx, input int st_len, input int pulse_cyc);
      int wr_cnt, st_left, exp_done, diffs, nops;
      bit prev_stall, wait_now;
      logic [49:0] prev_bus;
      logic [15:0] ra, wa;
      logic [31:0] w;
      exp_ops.delete();
      obs_ops.delete();
      for (int i = 0; i < int'(n); i++) begin
         ra = s + 16'(i);
         wa = d + 16'(i);
         if (fill) begin
            w = fdata;
         end else begin
            w = ref_mem[ra];
            exp_ops.push_back('{1'b0, ra, 32'h0});
         end
         ref_mem[wa] = w;
         exp_ops.push_back('{1'b1, wa, w});
      end

      src_addr = s; dst_addr = d; len = n;
`ifdef AVM_COPY_FILL_EN
      fill_mode = fill; fill_data = fdata;
`endif
      start = 1'b1;
      avm_waitrequest = 1'($urandom_range(0, 1));
      cyc = 0; wr_cnt = 0; st_left = st_len; stall_total = 0; done_cyc = -1;
      prev_stall = 1'b0; prev_bus = '0;
      @(posedge clk); #1;
      cyc = 1;
      while (done_cyc < 0 && cyc < LIMIT) begin
         drive_rdata();
         if (cyc == pulse_cyc) begin
            start = 1'b1; src_addr = $urandom(); dst_addr = $urandom(); len = 8'hFF;
         end else begin
            start = 1'b0;
         end
         case (mode)
            0:       wait_now = 1'b0;
            1:       wait_now = ($urandom_range(0, 3) == 0);
            default: wait_now = avm_write && wr_cnt == st_idx && st_left > 0;
         endcase
         avm_waitrequest = wait_now;
         @(negedge clk);
         check({tag, ":busy_high"}, busy, 1);
         check({tag, ":rd_wr_excl"}, avm_read & avm_write, 0);
         check({tag, ":cs"}, avm_chipselect, avm_read | avm_write);
         check({tag, ":byteen"}, avm_byteenable, avm_chipselect ? 4'hF : 4'h0);
         if (!avm_chipselect) check({tag, ":idle_bus"}, {avm_address, avm_writedata}, 0);
         if (prev_stall)
            check({tag, ":stall_hold"}, {avm_address, avm_writedata, avm_read, avm_write}, prev_bus);
         prev_stall = avm_chipselect && avm_waitrequest;
         prev_bus   = {avm_address, avm_writedata, avm_read, avm_write};
         if (avm_chipselect && avm_waitrequest) begin
            stall_total++;
            if (mode == 2) st_left--;
         end
         if (avm_chipselect && !avm_waitrequest) begin
            if (avm_write) begin
               obs_ops.push_back('{1'b1, avm_address, avm_writedata});
               mem[avm_address] = avm_writedata;
               wr_cnt++;
            end else begin
               obs_ops.push_back('{1'b0, avm_address, 32'h0});
               pend.push_back('{cyc + RL, mem[avm_address]});
            end
         end
         if (done === 1'b1) done_cyc = cyc;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      avm_waitrequest = 1'b0;
      check({tag, ":timeout"}, done_cyc >= 0, 1);
      check({tag, ":after_busy"}, busy, 0);
      check({tag, ":after_done"}, done, 0);
      exp_done = 1 + int'(n) * (fill ? 1 : RL + 2) + stall_total;
      check({tag, ":done_cycle"}, done_cyc, exp_done);
      check({tag, ":op_count"}, obs_ops.size(), exp_ops.size());
      nops = (obs_ops.size() < exp_ops.size()) ? obs_ops.size() : exp_ops.size();
      for (int i = 0; i < nops; i++)
         check({tag, ":op"}, {obs_ops[i].is_wr, obs_ops[i].addr, obs_ops[i].data},
               {exp_ops[i].is_wr, exp_ops[i].addr, exp_ops[i].data});
      diffs = 0;
      for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
      check({tag, ":mem_diffs"}, diffs, 0);
   endtask

   initial begin
      logic [15:0] a0, a2;
      reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
`ifdef AVM_COPY_FILL_EN
      fill_mode = 1'b0; fill_data = '0;
`endif
      avm_readdata = '0; avm_waitrequest = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         mem[i] = $urandom();
         ref_mem[i] = mem[i];
      end
      for (int i = 0; i < 4; i++) begin
         mem[i] = 32'h11 * (i + 1);
         ref_mem[i] = mem[i];
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1 check_all_idle("reset");
      reset = 1'b0;
      @(posedge clk); #1 check_all_idle("post_reset");

      // Basic copy: 0x11..0x44 from 0x0 to 0x8, done in cycle 13
      run_xfer("copy4", 16'h0000, 16'h0008, 8'd4, 1'b0, 32'h0, 0, 0, 0, -1);
      check("copy4:done13", done_cyc, 13);
      check("copy4:w8", mem[16'h8], 32'h11);
      check("copy4:w9", mem[16'h9], 32'h22);
      check("copy4:wA", mem[16'hA], 32'h33);
      check("copy4:wB", mem[16'hB], 32'h44);

      // Zero-length: done in cycle 1, no bus activity
      run_xfer("len0", 16'h1234, 16'h5678, 8'd0, 1'b0, 32'h0, 0, 0, 0, -1);
      check("len0:done1", done_cyc, 1);
      check("len0:no_ops", obs_ops.size(), 0);

      // Three stall cycles on the second write delay done by exactly 3
      run_xfer("stall", 16'h0040, 16'h0050, 8'd4, 1'b0, 32'h0, 2, 1, 3, -1);
      check("stall:done16", done_cyc, 16);

      // Source address wraps from 0xFFFF to 0x0000
      run_xfer("wrap", 16'hFFFF, 16'h0300, 8'd2, 1'b0, 32'h0, 0, 0, 0, -1);
      a0 = (obs_ops.size() > 0) ? obs_ops[0].addr : 16'h1111;
      a2 = (obs_ops.size() > 2) ? obs_ops[2].addr : 16'h1111;
      check("wrap:rd0", a0, 16'hFFFF);
      check("wrap:rd1", a2, 16'h0000);

      // Start pulsed while busy is ignored
      run_xfer("restart", 16'h0700, 16'h0900, 8'd5, 1'b0, 32'h0, 0, 0, 0, 3);

      // Reset in the middle of RD_WAIT abandons the transfer
      src_addr = 16'h0100; dst_addr = 16'h0200; len = 8'd3; start = 1'b1;
      avm_waitrequest = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk) check("rst_mid:rd_req", avm_read, 1);
      @(posedge clk); #1;
      check("rst_mid:in_wait_busy", busy, 1);
      check("rst_mid:in_wait_cs", avm_chipselect, 0);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check_all_idle("rst_mid");
      pend.delete();
      @(posedge clk); #1 check_all_idle("rst_mid_hold");
      run_xfer("after_rst", 16'h0100, 16'h0200, 8'd3, 1'b0, 32'h0, 0, 0, 0, -1);

      // Randomized copies with random waitrequest
      for (int t = 0; t < 6; t++)
         run_xfer("rand", 16'($urandom()), 16'($urandom()), 8'($urandom_range(1, 10)),
                  1'b0, 32'h0, 1, 0, 0, -1);

`ifdef AVM_COPY_FILL_EN
      // Fill mode: no reads, one cycle per word
      run_xfer("fill", 16'h0000, 16'h0020, 8'd3, 1'b1, 32'hDEADBEEF, 0, 0, 0, -1);
      check("fill:done4", done_cyc, 4);
      check("fill:w20", mem[16'h20], 32'hDEADBEEF);
      check("fill:w22", mem[16'h22], 32'hDEADBEEF);
      run_xfer("fill_rand", 16'($urandom()), 16'($urandom()), 8'd6, 1'b1, 32'($urandom()),
               1, 0, 0, -1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
